// File: rtl/ibuf_issue_pkg.sv
// rtl/ibuf_issue_pkg.sv - shared types and width helpers for the instruction buffer
//
// Purpose: queue entry {pc, inst} and interlock tracker entry {late_we, rd},
//          pointer/slot width helpers and their values at the default build
//          (XLEN=64, FETCH_W=2, DEPTH=8).
// Ports:   none (package).
package ibuf_issue_pkg;

  localparam int IBUF_XLEN    = 64;
  localparam int IBUF_FETCH_W = 2;
  localparam int IBUF_DEPTH   = 8;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int slot_w(input int fetch_w);
    return $clog2(fetch_w);
  endfunction

  localparam int PTR_W  = $clog2(IBUF_DEPTH) + 1;
  localparam int SLOT_W = $clog2(IBUF_FETCH_W);

  // pc is held at the widest supported PC width; narrower builds zero-extend.
  typedef struct packed {
    logic [IBUF_XLEN-1:0] pc;
    logic [31:0]          inst;
  } ibuf_entry_t;

  typedef struct packed {
    logic       late_we;
    logic [4:0] rd;
  } trk_entry_t;

endpackage

// File: rtl/ibuf_hazard_tracker.sv
// rtl/ibuf_hazard_tracker.sv - LAT-deep load/CSR-use interlock tracker
//
// Purpose: remembers the destinations of the last LAT accepted issue slots
//          whose result is produced late, and flags the decoded head
//          instruction if it reads one of them.
// Ports:   clk, rst_n (sync, active-low), flush    - clock, reset, clear
//          adv                                     - EX accepted a slot (shift)
//          fire                                    - head issued this cycle
//          dec_late, dec_we, dec_rd                - head's destination info
//          dec_rs1, dec_rs2                        - head's sources
//          hazard                                  - head must wait
module ibuf_hazard_tracker
  import ibuf_issue_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       adv,
  input  logic       fire,
  input  logic       dec_late,
  input  logic       dec_we,
  input  logic [4:0] dec_rd,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  output logic       hazard
);

  trk_entry_t trk [LAT];

  // The tracker counts accepted slots, so it only moves when EX takes a
  // slot; an interlocked slot still counts, carrying a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < LAT; i++) trk[i] <= '0;
    end else if (adv) begin
      trk[0] <= fire ? trk_entry_t'{late_we: dec_late & dec_we, rd: dec_rd} : '0;
      for (int i = 1; i < LAT; i++) trk[i] <= trk[i-1];
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (trk[i].late_we && (trk[i].rd != 5'd0) &&
          ((trk[i].rd == dec_rs1) || (trk[i].rd == dec_rs2)))
        hazard = 1'b1;
    end
  end

endmodule

// File: rtl/ibuf_issue.sv
// rtl/ibuf_issue.sv - instruction buffer and in-order issue stage
//
// Purpose: queues fetch lines of FETCH_W instructions (from the PC-aligned
//          slot onwards) in a DEPTH-entry circular buffer and issues one
//          instruction per cycle to EX, held off by a LAT-deep load/CSR-use
//          interlock. Define IBUF_BYPASS_EN to let an empty queue present the
//          incoming slot combinationally and issue it in the same cycle.
// Ports:   clk, rst_n (sync, active-low), flush
//          fetch_valid/fetch_ready, fetch_pc, fetch_line  - fetch side
//          id_valid/id_ready, id_pc, id_inst              - issue side
//          dec_rs1, dec_rs2, dec_rd, dec_we, dec_late      - decode of id_inst
//          stallreq_id                                     - head interlocked
//          occupancy                                       - queued entries
module ibuf_issue
  import ibuf_issue_pkg::*;
#(
  parameter int XLEN    = IBUF_XLEN,
  parameter int FETCH_W = IBUF_FETCH_W,
  parameter int DEPTH   = IBUF_DEPTH,
  parameter int LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [XLEN-1:0]               fetch_pc,
  input  logic [32*FETCH_W-1:0]         fetch_line,
  output logic                          id_valid,
  input  logic                          id_ready,
  output logic [XLEN-1:0]               id_pc,
  output logic [31:0]                   id_inst,
  input  logic [4:0]                    dec_rs1,
  input  logic [4:0]                    dec_rs2,
  input  logic [4:0]                    dec_rd,
  input  logic                          dec_we,
  input  logic                          dec_late,
  output logic                          stallreq_id,
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int PW = (DEPTH == IBUF_DEPTH) ? PTR_W : ptr_w(DEPTH);
  localparam int AW = PW - 1;
  // A single-slot line still gets a 1-bit slot index, tied to zero.
  localparam int SW = (FETCH_W == IBUF_FETCH_W) ? SLOT_W :
                      ((FETCH_W > 1) ? slot_w(FETCH_W) : 1);

  ibuf_entry_t       mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, occ, push_cnt;
  logic              empty, clr;
  logic              push_fire, pop_fire, fire;
  logic              byp_act, byp_pop, hazard, head_valid;
  logic [SW-1:0]     slot_s;
  logic [XLEN-1:0]   line_base;
  logic [XLEN-1:0]   slot_pc   [FETCH_W];
  logic [31:0]       slot_inst [FETCH_W];
  logic              wr_en     [FETCH_W];
  logic [AW-1:0]     wr_idx    [FETCH_W];
  ibuf_entry_t       head;

  assign clr   = ~rst_n | flush;
  assign occ   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);

  // Registered occupancy only: a pop in this cycle does not make room yet.
  assign fetch_ready = (occ <= PW'(DEPTH - FETCH_W));
  assign push_fire   = fetch_valid & fetch_ready;

  generate
    if (FETCH_W > 1) begin : g_slot
      assign slot_s = fetch_pc[2 +: SW];
    end else begin : g_noslot
      assign slot_s = '0;
    end
  endgenerate

  assign line_base = fetch_pc & ~XLEN'(FETCH_W * 4 - 1);

  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      slot_pc[k]   = line_base + XLEN'(4 * k);
      slot_inst[k] = fetch_line[32*k +: 32];
    end
  end

`ifdef IBUF_BYPASS_EN
  assign byp_act = empty & push_fire & ~clr;
`else
  assign byp_act = 1'b0;
`endif

  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr[AW-1:0]];
    end else if (byp_act) begin
      head.pc   = IBUF_XLEN'(slot_pc[slot_s]);
      head.inst = slot_inst[slot_s];
    end
  end

  assign head_valid  = ~empty | byp_act;
  assign id_valid    = head_valid & ~hazard;
  assign stallreq_id = head_valid & hazard;
  assign id_pc       = XLEN'(head.pc);
  assign id_inst     = head.inst;
  assign occupancy   = occ;

  assign fire     = id_valid & id_ready;
  assign pop_fire = fire & ~empty;
  // A bypassed instruction that issues immediately never occupies a slot.
  assign byp_pop  = byp_act & fire;

  // Slot k lands k-s entries past the write pointer (one fewer when slot s
  // was consumed by the bypass).
  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      wr_en[k]  = push_fire && (k >= int'(slot_s)) &&
                  !(byp_pop && (k == int'(slot_s)));
      wr_idx[k] = AW'(wr_ptr + PW'(k) - PW'(slot_s) - PW'(byp_pop));
    end
    push_cnt = push_fire ? (PW'(FETCH_W) - PW'(slot_s) - PW'(byp_pop)) : '0;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (wr_en[k])
          mem[wr_idx[k]] <= ibuf_entry_t'{pc: IBUF_XLEN'(slot_pc[k]), inst: slot_inst[k]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_cnt;
      if (pop_fire) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  ibuf_hazard_tracker #(.LAT(LAT)) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .adv      (id_ready),
    .fire     (fire),
    .dec_late (dec_late),
    .dec_we   (dec_we),
    .dec_rd   (dec_rd),
    .dec_rs1  (dec_rs1),
    .dec_rs2  (dec_rs2),
    .hazard   (hazard)
  );

endmodule

// File: tb/tb_ibuf_issue.sv
// tb/tb_ibuf_issue.sv - self-checking bench for ibuf_issue (FETCH_W=2, DEPTH=8, LAT=2)
module tb_ibuf_issue;

  localparam int FW    = 2;
  localparam int DEPTH = 8;
  localparam int LAT   = 2;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, fetch_valid, fetch_ready, id_valid, id_ready;
  logic [63:0] fetch_pc, id_pc;
  logic [63:0] fetch_line;
  logic [31:0] id_inst;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_we, dec_late, stallreq_id;
  logic [3:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  ibuf_issue #(.XLEN(64), .FETCH_W(FW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_line(fetch_line),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_we(dec_we), .dec_late(dec_late),
    .stallreq_id(stallreq_id), .occupancy(occupancy)
  );

  function automatic logic f_we(input logic [31:0] i);
    return !((i[6:0] == 7'h23) || (i[6:0] == 7'h63));
  endfunction
  function automatic logic f_late(input logic [31:0] i);
    return (i[6:0] == 7'h03) || ((i[6:0] == 7'h73) && (i[14:12] != 3'b000));
  endfunction
  function automatic logic [31:0] addi(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  assign dec_rs1  = id_inst[19:15];
  assign dec_rs2  = id_inst[24:20];
  assign dec_rd   = id_inst[11:7];
  assign dec_we   = f_we(id_inst);
  assign dec_late = f_late(id_inst);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: program-order queue, plus a list of pending late destinations
  // each with the number of accepted cycles it still blocks.
  logic [63:0] q_pc [$];
  logic [31:0] q_inst [$];
  int          trk_rd [$];
  int          trk_cnt [$];
  logic [63:0] issued [$];

  function automatic bit model_ready();
    return (DEPTH - q_pc.size()) >= FW;
  endfunction

  function automatic void model_head(output bit hv, output bit byp,
                                     output logic [63:0] pc, output logic [31:0] inst);
    hv = 0; byp = 0; pc = '0; inst = '0;
    if (q_pc.size() > 0) begin
      hv = 1; pc = q_pc[0]; inst = q_inst[0];
    end
`ifdef IBUF_BYPASS_EN
    else if (rst_n && !flush && fetch_valid && model_ready()) begin
      hv = 1; byp = 1;
      pc = {fetch_pc[63:3], fetch_pc[2], 2'b00};
      inst = fetch_pc[2] ? fetch_line[63:32] : fetch_line[31:0];
    end
`endif
  endfunction

  function automatic bit model_haz(input logic [31:0] inst);
    for (int i = 0; i < trk_rd.size(); i++)
      if (trk_rd[i] == int'(inst[19:15]) || trk_rd[i] == int'(inst[24:20])) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit hv, byp, fire, rdy;
    logic [63:0] pc;
    logic [31:0] inst;
    int s;
    if (!rst_n || flush) begin
      q_pc.delete(); q_inst.delete(); trk_rd.delete(); trk_cnt.delete();
    end else begin
      model_head(hv, byp, pc, inst);
      fire = hv && !model_haz(inst) && id_ready;
      rdy  = model_ready();
      if (fire) issued.push_back(pc);
      if (id_ready) begin
        for (int i = trk_cnt.size() - 1; i >= 0; i--) begin
          trk_cnt[i] = trk_cnt[i] - 1;
          if (trk_cnt[i] == 0) begin trk_cnt.delete(i); trk_rd.delete(i); end
        end
        if (fire && f_late(inst) && f_we(inst) && inst[11:7] != 5'd0) begin
          trk_rd.push_back(int'(inst[11:7]));
          trk_cnt.push_back(LAT);
        end
      end
      if (fire && !byp) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (fetch_valid && rdy) begin
        s = int'(fetch_pc[2]);
        for (int k = s; k < FW; k++) begin
          if (!(byp && fire && k == s)) begin
            q_pc.push_back({fetch_pc[63:3], 1'(k), 2'b00});
            q_inst.push_back(fetch_line[32*k +: 32]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit hv, byp, hz;
    logic [63:0] pc;
    logic [31:0] inst;
    if (chk_en) begin
      model_head(hv, byp, pc, inst);
      hz = hv && model_haz(inst);
      chk("cyc_id_valid",    64'(id_valid),    64'(hv && !hz));
      chk("cyc_stallreq_id", 64'(stallreq_id), 64'(hv && hz));
      chk("cyc_id_pc",       id_pc,            pc);
      chk("cyc_id_inst",     64'(id_inst),     64'(inst));
      chk("cyc_occupancy",   64'(occupancy),   64'(q_pc.size()));
      chk("cyc_fetch_ready", 64'(fetch_ready), 64'(model_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, nv;
    bit got;
    rst_n = 0; flush = 0; fetch_valid = 0; fetch_pc = '0; fetch_line = '0; id_ready = 0;
    tick(); tick(); chk_en = 1; #1;
    chk("rst_occupancy",   64'(occupancy),   64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_id_valid",    64'(id_valid),    64'd0);
    chk("rst_stallreq",    64'(stallreq_id), 64'd0);
    chk("rst_id_pc",       id_pc,            64'd0);
    rst_n = 1;

    // Misaligned line: only slot 1 is queued.
    tick(); fetch_valid = 1; fetch_pc = 64'h8000_0004; fetch_line = 64'h00A00093_00100013;
    tick(); fetch_valid = 0; #1;
    chk("t1_occupancy", 64'(occupancy), 64'd1);
    chk("t1_id_pc",     id_pc,          64'h8000_0004);
    chk("t1_id_inst",   64'(id_inst),   64'h00A00093);
    chk("t1_id_valid",  64'(id_valid),  64'd1);
    repeat (2) begin
      tick(); #1;
      chk("hold_id_pc",   id_pc,        64'h8000_0004);
      chk("hold_id_inst", 64'(id_inst), 64'h00A00093);
    end
    id_ready = 1; tick(); id_ready = 0; #1;
    chk("t1_drain_occ", 64'(occupancy), 64'd0);

    // Fill to full across the wrap, then drain in PC order.
    for (int i = 0; i < 4; i++) begin
      tick(); fetch_valid = 1; fetch_pc = 64'h1000 + 64'(8 * i);
      fetch_line = {addi(2 * i + 2), addi(2 * i + 1)};
    end
    tick(); fetch_pc = 64'h1020; fetch_line = {addi(10), addi(9)}; #1;
    chk("full_occupancy",   64'(occupancy),   64'd8);
    chk("full_fetch_ready", 64'(fetch_ready), 64'd0);
    tick(); fetch_valid = 0; id_ready = 1; issued.delete();
    repeat (10) tick();
    id_ready = 0; #1;
    chk("wrap_issue_count", 64'(issued.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("wrap_issue_pc", issued[i], 64'h1000 + 64'(4 * i));
    chk("wrap_empty_occ",   64'(occupancy), 64'd0);
    chk("wrap_empty_valid", 64'(id_valid),  64'd0);

    // ld x5 then add x6,x5,x1; EX holds for 3 cycles mid-stall.
    tick(); fetch_valid = 1; fetch_pc = 64'h2000; fetch_line = {32'h00128333, 32'h00053283};
    tick(); fetch_valid = 0; id_ready = 1;
    tick(); id_ready = 0; #1;
    chk("lu_stall_first", 64'(stallreq_id), 64'd1);
    chk("lu_head_inst",   64'(id_inst),     64'h00128333);
    repeat (3) begin
      tick(); #1;
      chk("lu_hold_stall", 64'(stallreq_id), 64'd1);
      chk("lu_hold_pc",    id_pc,            64'h2004);
    end
    id_ready = 1; stalls = 0; got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (!got) begin
        if (stallreq_id) stalls++;
        else if (id_valid) got = 1;
      end
      tick();
    end
    chk("lu_stall_cycles", 64'(stalls), 64'd2);
    chk("lu_add_issued",   64'(got),    64'd1);

    // ld x0 then add x6,x0,x1: no interlock.
    id_ready = 0;
    tick(); fetch_valid = 1; fetch_pc = 64'h2010; fetch_line = {32'h00100333, 32'h00053003};
    tick(); fetch_valid = 0; id_ready = 1; stalls = 0; nv = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (stallreq_id) stalls++;
      if (id_valid) nv++;
      tick();
    end
    id_ready = 0;
    chk("x0_stall_cycles", 64'(stalls), 64'd0);
    chk("x0_issue_count",  64'(nv),     64'd2);

    // Flush at occupancy 5 with a line on offer.
    tick(); fetch_valid = 1; fetch_pc = 64'h3004; fetch_line = {addi(3), addi(2)};
    tick(); fetch_pc = 64'h3008; fetch_line = {addi(5), addi(4)};
    tick(); fetch_pc = 64'h3010; fetch_line = {addi(7), addi(6)};
    tick(); fetch_pc = 64'h3018; fetch_line = {addi(9), addi(8)}; flush = 1; #1;
    chk("fl_pre_occ", 64'(occupancy), 64'd5);
    tick(); flush = 0; fetch_valid = 0; #1;
    chk("fl_occ",         64'(occupancy),   64'd0);
    chk("fl_id_valid",    64'(id_valid),    64'd0);
    chk("fl_fetch_ready", 64'(fetch_ready), 64'd1);
    tick(); fetch_valid = 1; fetch_pc = 64'h4000; fetch_line = {addi(12), addi(11)};
    tick(); fetch_valid = 0; #1;
    chk("fl_after_pc",  id_pc,          64'h4000);
    chk("fl_after_occ", 64'(occupancy), 64'd2);

    // Reset mid-operation.
    tick(); rst_n = 0;
    tick(); rst_n = 1; #1;
    chk("mid_rst_occ",   64'(occupancy), 64'd0);
    chk("mid_rst_valid", 64'(id_valid),  64'd0);

    // Empty queue, aligned push with EX ready.
    tick(); fetch_valid = 1; fetch_pc = 64'h5000; fetch_line = {32'h00300193, 32'h00200113};
    id_ready = 1; #1;
    chk("byp_id_valid", 64'(id_valid),  BYP ? 64'd1 : 64'd0);
    chk("byp_id_pc",    id_pc,          BYP ? 64'h5000 : 64'd0);
    chk("byp_id_inst",  64'(id_inst),   BYP ? 64'h00200113 : 64'd0);
    tick(); fetch_valid = 0; id_ready = 0; #1;
    chk("byp_occ", 64'(occupancy), BYP ? 64'd1 : 64'd2);

    id_ready = 1;
    repeat (4) tick();
    id_ready = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
